// File: rtl/uart_imem_loader_if.sv
// Instruction-memory write port driven by the boot loader.
interface uart_imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (output imem_we, output imem_addr, output imem_wdata);
    modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);
endinterface

// File: rtl/uart_imem_loader.sv
// Boot loader: receives a length-prefixed image over UART 8N1, packs
// bytes into little-endian 32-bit words, writes them into imem and
// releases the core reset once the whole image has landed.
module uart_imem_loader #(
    parameter int CLKS_PER_BIT = 104,
    parameter int IMEM_WORDS   = 256,
    parameter int ADDR_W       = $clog2(IMEM_WORDS)
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic                       rx,
    uart_imem_loader_if.master         imem,
    output logic                       core_rstN,
    output logic                       busy,
    output logic                       error
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [2:0] {L_LEN0, L_LEN1, L_DATA, L_DONE, L_ERR} ld_state_e;

    // ---------------- rx synchroniser ----------------
    logic rx_meta_q, rx_sync_q;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // ---------------- UART receiver ----------------
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid, frame_err;
    logic [7:0]       rx_byte;

    // Receiver state and bit-timing registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rx_state_q <= RX_IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
        end
    end

    // Receiver next state: half-bit to centre on the start bit, then whole bits.
    always_comb begin
        rx_state_d = rx_state_q;
        clk_cnt_d  = clk_cnt_q + CNT_W'(1);
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        case (rx_state_q)
            RX_IDLE: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                if (!rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (clk_cnt_q == HALF_END) begin
                    clk_cnt_d  = '0;
                    // Still high at mid start bit means it was a glitch.
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == BIT_END) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (clk_cnt_q == BIT_END) begin
                    clk_cnt_d  = '0;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Receiver outputs: one-cycle byte or framing-error pulse at mid stop bit.
    always_comb begin
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        rx_byte    = shift_q;
        if (rx_state_q == RX_STOP && clk_cnt_q == BIT_END) begin
            byte_valid = rx_sync_q;
            frame_err  = !rx_sync_q;
        end
    end

    // ---------------- loader ----------------
    ld_state_e         ld_state_q, ld_state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       hdr_len;

    assign hdr_len = {rx_byte, len_q[7:0]};

    // Loader state, word assembly and imem port registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ld_state_q <= L_LEN0;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_idx_q <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
        end else begin
            ld_state_q <= ld_state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_idx_q <= byte_idx_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
        end
    end

    // Loader next state: header, then words; DONE and ERR are terminal.
    always_comb begin
        ld_state_d = ld_state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        case (ld_state_q)
            L_LEN0: begin
                if (byte_valid) begin
                    len_d[7:0] = rx_byte;
                    ld_state_d = L_LEN1;
                end
                if (frame_err) ld_state_d = L_ERR;
            end
            L_LEN1: begin
                if (byte_valid) begin
                    len_d      = hdr_len;
                    word_cnt_d = '0;
                    byte_idx_d = '0;
                    if (hdr_len == 16'd0)
                        ld_state_d = L_DONE;
                    else if ({16'd0, hdr_len} > IMEM_WORDS)
                        ld_state_d = L_ERR;
                    else
                        ld_state_d = L_DATA;
                end
                if (frame_err) ld_state_d = L_ERR;
            end
            L_DATA: begin
                // Strobe cycle: advance the counter; last word ends the load.
                if (we_q) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (16'(word_cnt_q) + 16'd1 == len_q) ld_state_d = L_DONE;
                end
                if (byte_valid) begin
                    wdata_d[{byte_idx_q, 3'b000} +: 8] = rx_byte;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        we_d   = 1'b1;
                        addr_d = word_cnt_q[ADDR_W-1:0];
                    end
                end
                if (frame_err) ld_state_d = L_ERR;
            end
            L_DONE:  ld_state_d = L_DONE;
            L_ERR:   ld_state_d = L_ERR;
            default: ld_state_d = L_ERR;
        endcase
    end

    // Loader outputs: core stays in reset unless the image completed.
    always_comb begin
        core_rstN       = (ld_state_q == L_DONE);
        busy            = (ld_state_q != L_DONE);
        error           = (ld_state_q == L_ERR);
        imem.imem_we    = we_q;
        imem.imem_addr  = addr_q;
        imem.imem_wdata = wdata_q;
    end
endmodule
